// File: rtl/bus_cmd.sv
// bus_cmd: decodes the MCU command byte stream into single 8-bit PET bus
// transactions. Address, write data and direction are latched from the byte
// stream; 'pending' is held towards the bus-cycle synchronizer until it
// answers with 'done', at which point read data is captured and reported.
module bus_cmd #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  done,
  input  logic [7:0]            bus_rd_data,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  output logic                  bus_rw_b,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_WAIT,
    ST_IGNORE
  } state_t;

  state_t state;

  // Command byte reserved bits [4:1] carry no meaning.
  logic unused_reserved;
  assign unused_reserved = ^rx_data[4:1];

  // Candidate next addresses, built on a 17-bit view so that the A16 handling
  // collapses away cleanly when the bus is only 16 bits wide.
  logic [16:0]           addr_ext;
  logic [16:0]           addr_with_a16;
  logic [16:0]           addr_with_hi;
  logic [16:0]           addr_with_lo;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Address update candidates for each decoder step.
  always_comb begin
    addr_ext      = 17'(bus_addr);
    addr_with_a16 = {rx_data[0], addr_ext[15:0]};
    addr_with_hi  = {addr_ext[16], rx_data, addr_ext[7:0]};
    addr_with_lo  = {addr_ext[16:8], rx_data};
    addr_inc      = bus_addr + ADDR_WIDTH'(1);
  end

  // Command decoder, transaction hand-off and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_CMD;
      pending     <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_rw_b    <= 1'b1;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == ST_WAIT) begin
        // A frame restart during WAIT must not abort the bus cycle: the cycle
        // still completes on done, only the overrun flag is affected here.
        if (done) begin
          state   <= ST_CMD;
          pending <= 1'b0;
          busy    <= 1'b0;
          if (bus_rw_b) begin
            rd_data  <= bus_rd_data;
            rd_valid <= 1'b1;
          end
        end
        if (rx_start) begin
          overrun <= 1'b0;
        end else if (rx_valid) begin
          overrun <= 1'b1;
        end
      end else if (rx_start) begin
        state   <= ST_CMD;
        overrun <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          ST_CMD: begin
            if (rx_data[7]) begin
              state <= ST_IGNORE;
            end else begin
              bus_rw_b <= rx_data[6];
              if (rx_data[5]) begin
                bus_addr <= addr_inc;
                if (rx_data[6]) begin
                  state   <= ST_WAIT;
                  pending <= 1'b1;
                  busy    <= 1'b1;
                end else begin
                  state <= ST_DATA;
                end
              end else begin
                bus_addr <= ADDR_WIDTH'(addr_with_a16);
                state    <= ST_ADDR_HI;
              end
            end
          end
          ST_ADDR_HI: begin
            bus_addr <= ADDR_WIDTH'(addr_with_hi);
            state    <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            bus_addr <= ADDR_WIDTH'(addr_with_lo);
            if (bus_rw_b) begin
              state   <= ST_WAIT;
              pending <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            bus_wr_data <= rx_data;
            state       <= ST_WAIT;
            pending     <= 1'b1;
            busy        <= 1'b1;
          end
          ST_IGNORE: begin
            state <= ST_IGNORE;
          end
          default: begin
            state <= ST_CMD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_cmd.sv
// Directed self-checking bench for bus_cmd (ADDR_WIDTH = 17).
module tb_bus_cmd;

  logic        clk;
  logic        reset_n;
  logic        rx_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        done;
  logic [7:0]  bus_rd_data;
  logic        pending;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_rw_b;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        overrun;

  int tests;
  int fails;

  bus_cmd #(.ADDR_WIDTH(17)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_start    (rx_start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .done        (done),
    .bus_rd_data (bus_rd_data),
    .pending     (pending),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rw_b    (bus_rw_b),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_start();
    @(negedge clk);
    rx_start = 1'b1;
    @(posedge clk);
    #1;
    rx_start = 1'b0;
  endtask

  // One-cycle done pulse with the given read data; returns #1 after the edge.
  task automatic pulse_done(input logic [7:0] d);
    @(negedge clk);
    done        = 1'b1;
    bus_rd_data = d;
    @(posedge clk);
    #1;
    done = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset_n     = 1'b0;
    rx_start    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    done        = 1'b0;
    bus_rd_data = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending",  32'(pending),     32'h0);
    chk("rst_addr",     32'(bus_addr),    32'h0);
    chk("rst_wr_data",  32'(bus_wr_data), 32'h0);
    chk("rst_rw_b",     32'(bus_rw_b),    32'h1);
    chk("rst_rd_data",  32'(rd_data),     32'h0);
    chk("rst_rd_valid", 32'(rd_valid),    32'h0);
    chk("rst_busy",     32'(busy),        32'h0);
    chk("rst_overrun",  32'(overrun),     32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write 0x08000 = 0x55
    send_byte(8'h00);
    send_byte(8'h80);
    send_byte(8'h00);
    chk("wr_pend_early", 32'(pending), 32'h0);
    send_byte(8'h55);
    chk("wr_pending", 32'(pending),     32'h1);
    chk("wr_busy",    32'(busy),        32'h1);
    chk("wr_addr",    32'(bus_addr),    32'h08000);
    chk("wr_data",    32'(bus_wr_data), 32'h55);
    chk("wr_rw_b",    32'(bus_rw_b),    32'h0);
    idle_cycle();
    chk("wr_hold",    32'(pending),     32'h1);
    pulse_done(8'hEE);
    chk("wr_done_pending",  32'(pending),  32'h0);
    chk("wr_done_busy",     32'(busy),     32'h0);
    chk("wr_done_rd_valid", 32'(rd_valid), 32'h0);
    chk("wr_done_rd_data",  32'(rd_data),  32'h0);

    // Read 0x11234 -> A5
    send_byte(8'h41);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("rd_pending", 32'(pending),  32'h1);
    chk("rd_addr",    32'(bus_addr), 32'h11234);
    chk("rd_rw_b",    32'(bus_rw_b), 32'h1);
    pulse_done(8'hA5);
    chk("rd_data",       32'(rd_data),  32'hA5);
    chk("rd_valid_on",   32'(rd_valid), 32'h1);
    chk("rd_done_pend",  32'(pending),  32'h0);
    idle_cycle();
    chk("rd_valid_off",  32'(rd_valid), 32'h0);

    // Read-next wrap from 0x1FFFF
    send_byte(8'h41);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("wrap_pre_addr", 32'(bus_addr), 32'h1FFFF);
    pulse_done(8'h00);
    send_byte(8'h60);
    chk("wrap_pending", 32'(pending),  32'h1);
    chk("wrap_addr",    32'(bus_addr), 32'h00000);
    chk("wrap_rw_b",    32'(bus_rw_b), 32'h1);
    pulse_done(8'h3A);
    chk("wrap_rd_data", 32'(rd_data), 32'h3A);

    // Write-next: 0x00001 = 0x3C
    send_byte(8'h20);
    chk("wn_addr",     32'(bus_addr), 32'h00001);
    chk("wn_pend_mid", 32'(pending),  32'h0);
    send_byte(8'h3C);
    chk("wn_pending", 32'(pending),     32'h1);
    chk("wn_data",    32'(bus_wr_data), 32'h3C);
    chk("wn_rw_b",    32'(bus_rw_b),    32'h0);
    pulse_done(8'h00);
    chk("wn_rd_valid", 32'(rd_valid), 32'h0);

    // Overrun and restart inside WAIT
    send_byte(8'h41);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h77);
    chk("ovr_set",     32'(overrun),     32'h1);
    chk("ovr_pending", 32'(pending),     32'h1);
    chk("ovr_wr_data", 32'(bus_wr_data), 32'h3C);
    chk("ovr_addr",    32'(bus_addr),    32'h10005);
    send_start();
    chk("ovr_clear",    32'(overrun), 32'h0);
    chk("ovr_pend_kept", 32'(pending), 32'h1);
    pulse_done(8'h5A);
    chk("ovr_rd_data",  32'(rd_data),  32'h5A);
    chk("ovr_rd_valid", 32'(rd_valid), 32'h1);
    send_byte(8'h41);
    send_byte(8'h00);
    send_byte(8'h01);
    chk("ovr_next_addr", 32'(bus_addr), 32'h10001);
    chk("ovr_next_pend", 32'(pending),  32'h1);

    // rx_start together with rx_valid in WAIT: start wins, no overrun
    @(negedge clk);
    rx_start = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    rx_start = 1'b0;
    rx_valid = 1'b0;
    chk("both_overrun", 32'(overrun), 32'h0);
    chk("both_pending", 32'(pending), 32'h1);
    pulse_done(8'hC3);
    chk("both_rd_data", 32'(rd_data), 32'hC3);

    // Invalid command, then recovery via rx_start
    send_byte(8'hC0);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("inv_pending", 32'(pending),  32'h0);
    chk("inv_addr",    32'(bus_addr), 32'h10001);
    chk("inv_busy",    32'(busy),     32'h0);
    send_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hAA);
    chk("inv_rec_pending", 32'(pending),     32'h1);
    chk("inv_rec_addr",    32'(bus_addr),    32'h00010);
    chk("inv_rec_data",    32'(bus_wr_data), 32'hAA);
    chk("inv_rec_rw_b",    32'(bus_rw_b),    32'h0);

    // Asynchronous reset mid-WAIT, checked before any further edge
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_pending", 32'(pending),  32'h0);
    chk("arst_busy",    32'(busy),     32'h0);
    chk("arst_addr",    32'(bus_addr), 32'h0);
    chk("arst_rw_b",    32'(bus_rw_b), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
